branch_pred_ctrl: RTL and testbench
===================================

Name: branch_pred_ctrl

Overview:
- Sequencing controller for the GShare predictor; sits between IF, EX and the predictor's PHT write port.
- Owns the speculative global history (GHR), updated at IF prediction time.
- Tracks in-flight predicted branches in an in-order checkpoint queue, schedules PHT training writes at resolve, and detects mispredicts (flush plus GHR restore).
- After reset, sweeps the PHT to weak-not-taken, one entry per cycle.

Parameters:
- PHT_ENTRIES, 32, number of PHT counters; equals 2**GHR_BITS.
- GHR_BITS, 5, history/index width.
- DEPTH, 4, in-flight checkpoint slots; power of two, >=2.
- TAG_W, $clog2(DEPTH), checkpoint tag width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_br_valid  in  1  IF predicted a branch this cycle.
- if_pht_idx  in  GHR_BITS  PHT index used for that prediction.
- if_pred_taken  in  1  predicted direction.
- if_ready  out  1  slot free and state RUN; allocation occurs on if_br_valid && if_ready.
- if_tag  out  TAG_W  tag assigned to the allocating branch (tail pointer).
- ghr_spec  out  GHR_BITS  speculative history fed to the IF hash.
- ex_resolve_valid  in  1  EX resolves a branch.
- ex_tag  in  TAG_W  tag of the resolving branch.
- ex_actual_taken  in  1  actual direction.
- pht_we  out  1  PHT write strobe.
- pht_waddr  out  GHR_BITS  PHT entry to write.
- pht_init  out  1  1: write 2'b01; 0: saturating train.
- pht_inc  out  1  train direction (1 increment, 0 decrement); valid when pht_we && !pht_init.
- flush  out  1  one-cycle mispredict pulse.
- err  out  1  sticky protocol error.

Behaviour:
- Reset (async, rst_n=0): state INIT, ghr_spec=0, queue empty (head=tail=count=0), all outputs 0 except pht_we=1, pht_init=1, pht_waddr=0. This holds for reset asserted mid-operation as well.
- INIT: each cycle pht_we=1, pht_init=1, pht_waddr counts 0..PHT_ENTRIES-1. After the last entry, go to RUN; INIT lasts exactly PHT_ENTRIES cycles. if_ready=0; resolves are ignored and set err.
- RUN:
  - if_ready = (count<DEPTH).
  - On allocation: slot[tail] <= {if_pht_idx, if_pred_taken, ghr_spec}; tail++ (wraps mod DEPTH); ghr_spec <= {ghr_spec[GHR_BITS-2:0], if_pred_taken}.
  - if_tag = tail, combinational.
- Resolve in RUN, valid when count>0 and ex_tag==head:
  - Pop head.
  - The next cycle: pht_we=1, pht_init=0, pht_waddr=slot.idx, pht_inc=ex_actual_taken (1-cycle registered latency).
- Mispredict (ex_actual_taken != slot.pred):
  - Next cycle: flush=1 and ghr_spec <= {slot.ghr[GHR_BITS-2:0], ex_actual_taken}.
  - The queue is emptied (all younger branches squashed); go to RECOVER.
- RECOVER: one cycle, if_ready=0, then RUN.
- Correct prediction: ghr_spec is not restored.
- Simultaneous allocation and correct resolve: both take effect; count is unchanged; full-queue allocation is still blocked by if_ready.
- Simultaneous allocation and mispredicting resolve: the allocation is discarded (younger), and its GHR shift is discarded.
- Resolve with count==0 or ex_tag!=head: ignored; err<=1 (sticky until reset).
- A resolve during RECOVER is ignored and sets err.
- No PHT write in the cycle immediately after a discarded resolve.

Decomposition:
- Package bp_pkg:
  - ckpt_t struct {idx, pred, ghr}.
  - ctrl_state_e enum {INIT, RUN, RECOVER}.
  - Shared GHR_BITS default.
- Sub-module bp_ckpt_fifo: DEPTH-entry circular queue.
  - Signals: push/pop/clear, head/tail tags, count, full/empty.
  - Combinational head read.

Test Plan:
- Reset release -> pht_we=1, pht_init=1 for 32 cycles, addr 0..31; if_ready=0 throughout; if_ready=1 on cycle 33.
- 4 allocations, pred taken, ghr_spec=0 -> ghr_spec=5'b01111, tags 0,1,2,3; if_ready=0; a 5th if_br_valid is not accepted.
- Resolve tag 0 taken (pred taken, idx 7) -> next cycle pht_we=1, waddr=7, pht_inc=1, pht_init=0, flush=0; count=3.
- Resolve tag 1 not-taken (pred taken, snapshot 5'b00001) -> flush pulse one cycle; ghr_spec=5'b00010; queue empty; if_ready=0 for 1 cycle, then 1.
- Allocation in the same cycle as a mispredicting resolve -> allocation dropped; tail equals head after recovery; ghr_spec equals the restored value.
- Resolve with wrong tag or empty queue -> no pht_we, err=1 sticky. rst_n pulse mid-INIT (addr 10) -> sweep restarts at 0; err cleared.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types for the GShare sequencing controller: controller states,
// the in-flight checkpoint record and the history shift helper.
package bp_pkg;

    localparam int BP_GHR_BITS = 5;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        RECOVER = 2'd2
    } ctrl_state_e;

    // Snapshot taken at prediction time; ghr is the history *before* the shift.
    typedef struct packed {
        logic [BP_GHR_BITS-1:0] idx;
        logic                   pred;
        logic [BP_GHR_BITS-1:0] ghr;
    } ckpt_t;

    function automatic logic [BP_GHR_BITS-1:0] ghr_shift(
        input logic [BP_GHR_BITS-1:0] ghr,
        input logic                   dir
    );
        return {ghr[BP_GHR_BITS-2:0], dir};
    endfunction

endpackage

// File: rtl/branch_pred_ctrl_if.sv
// IF / EX / PHT-write signal bundle of the branch predictor controller.
interface branch_pred_ctrl_if #(
    parameter int GHR_BITS = 5,
    parameter int TAG_W    = 2
);
    logic                if_br_valid;
    logic [GHR_BITS-1:0] if_pht_idx;
    logic                if_pred_taken;
    logic                if_ready;
    logic [TAG_W-1:0]    if_tag;
    logic [GHR_BITS-1:0] ghr_spec;
    logic                ex_resolve_valid;
    logic [TAG_W-1:0]    ex_tag;
    logic                ex_actual_taken;
    logic                pht_we;
    logic [GHR_BITS-1:0] pht_waddr;
    logic                pht_init;
    logic                pht_inc;
    logic                flush;
    logic                err;

    modport master (
        output if_br_valid, if_pht_idx, if_pred_taken,
        output ex_resolve_valid, ex_tag, ex_actual_taken,
        input  if_ready, if_tag, ghr_spec,
        input  pht_we, pht_waddr, pht_init, pht_inc, flush, err
    );

    modport slave (
        input  if_br_valid, if_pht_idx, if_pred_taken,
        input  ex_resolve_valid, ex_tag, ex_actual_taken,
        output if_ready, if_tag, ghr_spec,
        output pht_we, pht_waddr, pht_init, pht_inc, flush, err
    );
endinterface

// File: rtl/bp_ckpt_fifo.sv
// In-order checkpoint queue: circular buffer of in-flight predicted branches,
// head slot readable combinationally, clear squashes everything.
module bp_ckpt_fifo
    import bp_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  ckpt_t            wdata,
    output ckpt_t            head_data,
    output logic [TAG_W-1:0] head,
    output logic [TAG_W-1:0] tail,
    output logic             full,
    output logic             empty
);
    localparam int               CNT_W   = TAG_W + 1;
    localparam int               CKPT_W  = $bits(ckpt_t);
    localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    ckpt_t            slot_r [DEPTH];
    logic [TAG_W-1:0] head_r;
    logic [TAG_W-1:0] tail_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_MAX);
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign head      = head_r;
    assign tail      = tail_r;
    assign head_data = slot_r[head_r];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= {TAG_W{1'b0}};
            tail_r  <= {TAG_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            head_r  <= {TAG_W{1'b0}};
            tail_r  <= {TAG_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                tail_r <= tail_r + TAG_ONE;
            end
            if (pop_ok_s) begin
                head_r <= head_r + TAG_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Checkpoint storage, written at the tail on accepted pushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_r[i] <= ckpt_t'({CKPT_W{1'b0}});
            end
        end else if (push_ok_s && !clear) begin
            slot_r[tail_r] <= wdata;
        end
    end

endmodule

// File: rtl/branch_pred_ctrl.sv
// GShare sequencing controller: speculative history, in-flight checkpoints,
// PHT init sweep and training writes, mispredict flush and history restore.
module branch_pred_ctrl
    import bp_pkg::*;
#(
    parameter  int PHT_ENTRIES = 32,
    parameter  int GHR_BITS    = BP_GHR_BITS,
    parameter  int DEPTH       = 4,
    localparam int TAG_W       = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    branch_pred_ctrl_if.slave  bus
);
    localparam logic [GHR_BITS-1:0] LAST_IDX = GHR_BITS'(PHT_ENTRIES - 1);
    localparam logic [GHR_BITS-1:0] IDX_ONE  = GHR_BITS'(1);

    ctrl_state_e         state_r;
    logic [GHR_BITS-1:0] ghr_r;
    logic                pht_we_r;
    logic [GHR_BITS-1:0] pht_waddr_r;
    logic                pht_init_r;
    logic                pht_inc_r;
    logic                flush_r;
    logic                err_r;

    ckpt_t               head_slot_s;
    ckpt_t               push_data_s;
    logic [TAG_W-1:0]    head_s;
    logic [TAG_W-1:0]    tail_s;
    logic                full_s;
    logic                empty_s;
    logic                if_ready_s;
    logic                alloc_s;
    logic                resolve_hit_s;
    logic                resolve_bad_s;
    logic                mispredict_s;
    logic                push_s;
    logic                pop_s;
    logic                clear_s;

    assign push_data_s = '{idx: bus.if_pht_idx, pred: bus.if_pred_taken, ghr: ghr_r};

    bp_ckpt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .pop       (pop_s),
        .clear     (clear_s),
        .wdata     (push_data_s),
        .head_data (head_slot_s),
        .head      (head_s),
        .tail      (tail_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Allocation/resolve qualification; a mispredict squashes the same-cycle allocation.
    always_comb begin
        if_ready_s    = (state_r == RUN) && !full_s;
        alloc_s       = bus.if_br_valid && if_ready_s;
        resolve_hit_s = bus.ex_resolve_valid && (state_r == RUN) && !empty_s
                        && (bus.ex_tag == head_s);
        resolve_bad_s = bus.ex_resolve_valid && !resolve_hit_s;
        mispredict_s  = resolve_hit_s && (bus.ex_actual_taken != head_slot_s.pred);
        push_s        = alloc_s && !mispredict_s;
        pop_s         = resolve_hit_s && !mispredict_s;
        clear_s       = mispredict_s;
    end

    // Controller FSM with registered PHT-write, flush, error and history outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= INIT;
            ghr_r       <= {GHR_BITS{1'b0}};
            pht_we_r    <= 1'b1;
            pht_waddr_r <= {GHR_BITS{1'b0}};
            pht_init_r  <= 1'b1;
            pht_inc_r   <= 1'b0;
            flush_r     <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            flush_r <= 1'b0;
            err_r   <= err_r | resolve_bad_s;
            case (state_r)
                INIT: begin
                    pht_inc_r <= 1'b0;
                    if (pht_waddr_r == LAST_IDX) begin
                        state_r     <= RUN;
                        pht_we_r    <= 1'b0;
                        pht_init_r  <= 1'b0;
                        pht_waddr_r <= {GHR_BITS{1'b0}};
                    end else begin
                        pht_we_r    <= 1'b1;
                        pht_init_r  <= 1'b1;
                        pht_waddr_r <= pht_waddr_r + IDX_ONE;
                    end
                end
                RUN: begin
                    pht_init_r <= 1'b0;
                    if (resolve_hit_s) begin
                        pht_we_r    <= 1'b1;
                        pht_waddr_r <= head_slot_s.idx;
                        pht_inc_r   <= bus.ex_actual_taken;
                    end else begin
                        pht_we_r    <= 1'b0;
                        pht_waddr_r <= {GHR_BITS{1'b0}};
                        pht_inc_r   <= 1'b0;
                    end
                    // Restore from the pre-prediction snapshot plus the real outcome.
                    if (mispredict_s) begin
                        flush_r <= 1'b1;
                        ghr_r   <= ghr_shift(head_slot_s.ghr, bus.ex_actual_taken);
                        state_r <= RECOVER;
                    end else if (alloc_s) begin
                        ghr_r <= ghr_shift(ghr_r, bus.if_pred_taken);
                    end else begin
                        ghr_r <= ghr_r;
                    end
                end
                RECOVER: begin
                    state_r     <= RUN;
                    pht_we_r    <= 1'b0;
                    pht_init_r  <= 1'b0;
                    pht_waddr_r <= {GHR_BITS{1'b0}};
                    pht_inc_r   <= 1'b0;
                end
                default: begin
                    state_r     <= INIT;
                    pht_we_r    <= 1'b1;
                    pht_init_r  <= 1'b1;
                    pht_waddr_r <= {GHR_BITS{1'b0}};
                    pht_inc_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.if_ready  = if_ready_s;
    assign bus.if_tag    = tail_s;
    assign bus.ghr_spec  = ghr_r;
    assign bus.pht_we    = pht_we_r;
    assign bus.pht_waddr = pht_waddr_r;
    assign bus.pht_init  = pht_init_r;
    assign bus.pht_inc   = pht_inc_r;
    assign bus.flush     = flush_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Bench for branch_pred_ctrl: directed scenarios plus randomized traffic
// checked against a queue-based behavioural model.
module tb_branch_pred_ctrl;
    localparam int GB    = 5;
    localparam int DEPTH = 4;
    localparam int TW    = 2;
    localparam int NENT  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_pred_ctrl_if #(.GHR_BITS(GB), .TAG_W(TW)) bus ();

    branch_pred_ctrl #(.PHT_ENTRIES(NENT), .GHR_BITS(GB), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        int tag;
        int idx;
        bit pred;
        int ghr;
    } br_t;

    br_t m_q[$];
    int  m_tail, m_ghr, m_sweep;
    bit  m_in_sweep, m_recover;
    bit  e_we, e_init, e_inc, e_flush, e_err;
    int  e_waddr;
    bit  m_pre_ready;
    int  m_pre_tag;
    logic          d_pre_ready;
    logic [TW-1:0] d_pre_tag;

    task automatic model_reset();
        m_q.delete();
        m_tail = 0; m_ghr = 0; m_sweep = 0;
        m_in_sweep = 1'b1; m_recover = 1'b0;
        e_we = 1'b1; e_init = 1'b1; e_inc = 1'b0; e_flush = 1'b0; e_err = 1'b0;
        e_waddr = 0;
    endtask

    task automatic drive_idle();
        bus.if_br_valid = 1'b0; bus.if_pht_idx = '0; bus.if_pred_taken = 1'b0;
        bus.ex_resolve_valid = 1'b0; bus.ex_tag = '0; bus.ex_actual_taken = 1'b0;
    endtask

    // One clock: drive inputs, capture pre-edge DUT/model handshake, advance the model.
    task automatic tick(input bit v, input int idx, input bit pred,
                        input bit rv, input int tag, input bit act);
        bit alloc, hit;
        br_t e;
        bus.if_br_valid = v; bus.if_pht_idx = idx[GB-1:0]; bus.if_pred_taken = pred;
        bus.ex_resolve_valid = rv; bus.ex_tag = tag[TW-1:0]; bus.ex_actual_taken = act;
        m_pre_ready = !m_in_sweep && !m_recover && (m_q.size() < DEPTH);
        m_pre_tag = m_tail;
        #1;
        d_pre_ready = bus.if_ready;
        d_pre_tag = bus.if_tag;
        @(posedge clk);
        #1;
        alloc = v && m_pre_ready;
        hit = rv && !m_in_sweep && !m_recover && (m_q.size() > 0) && (m_q[0].tag == tag);
        if (rv && !hit) e_err = 1'b1;
        e_flush = 1'b0;
        if (m_in_sweep) begin
            if (m_sweep == NENT - 1) begin
                m_in_sweep = 1'b0; e_we = 1'b0; e_init = 1'b0; e_waddr = 0;
            end else begin
                m_sweep++; e_waddr = m_sweep;
            end
        end else if (m_recover) begin
            m_recover = 1'b0; e_we = 1'b0; e_init = 1'b0; e_waddr = 0; e_inc = 1'b0;
        end else begin
            e_we = 1'b0; e_init = 1'b0; e_waddr = 0; e_inc = 1'b0;
            if (hit) begin
                e = m_q.pop_front();
                e_we = 1'b1; e_waddr = e.idx; e_inc = act;
                if (act != e.pred) begin
                    e_flush = 1'b1;
                    m_ghr = ((e.ghr << 1) | int'(act)) % NENT;
                    m_q.delete(); m_tail = 0; m_recover = 1'b1; alloc = 1'b0;
                end
            end
            if (alloc) begin
                m_q.push_back('{m_tail, idx, pred, m_ghr});
                m_tail = (m_tail + 1) % DEPTH;
                m_ghr = ((m_ghr << 1) | int'(pred)) % NENT;
            end
        end
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.pht_we, bus.pht_init, bus.pht_waddr, bus.flush, bus.err, bus.ghr_spec, bus.if_ready}
            !== {1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got we=%b init=%b addr=%0d flush=%b err=%b ghr=%b rdy=%b",
                     bus.pht_we, bus.pht_init, bus.pht_waddr, bus.flush, bus.err, bus.ghr_spec, bus.if_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NENT; i++) begin
            checks++;
            if ({bus.pht_we, bus.pht_init, bus.pht_waddr} !== {1'b1, 1'b1, 5'(i)}) begin
                failures++;
                $display("FAIL init_sweep cycle %0d got we=%b init=%b addr=%0d exp addr=%0d",
                         i, bus.pht_we, bus.pht_init, bus.pht_waddr, i);
            end
            tick(0, 0, 0, 0, 0, 0);
            checks++;
            if (d_pre_ready !== 1'b0) begin
                failures++;
                $display("FAIL init_ready cycle %0d got=%b exp=0", i, d_pre_ready);
            end
        end
        checks++;
        if ({bus.if_ready, bus.pht_we, bus.pht_init} !== 3'b100) begin
            failures++;
            $display("FAIL run_entry got rdy=%b we=%b init=%b exp 1/0/0",
                     bus.if_ready, bus.pht_we, bus.pht_init);
        end
    endtask

    task automatic test_fill();
        int idxs[4] = '{7, 3, 9, 1};
        for (int i = 0; i < 4; i++) begin
            tick(1, idxs[i], 1, 0, 0, 0);
            checks++;
            if ({d_pre_ready, d_pre_tag} !== {1'b1, 2'(i)}) begin
                failures++;
                $display("FAIL fill_tag %0d got rdy=%b tag=%0d exp rdy=1 tag=%0d", i, d_pre_ready, d_pre_tag, i);
            end
        end
        checks++;
        if ({bus.ghr_spec, bus.if_ready} !== {5'b01111, 1'b0}) begin
            failures++;
            $display("FAIL fill_ghr got ghr=%b rdy=%b exp ghr=01111 rdy=0", bus.ghr_spec, bus.if_ready);
        end
        tick(1, 12, 1, 0, 0, 0);
        checks++;
        if ({d_pre_ready, bus.ghr_spec, bus.pht_we} !== {1'b0, 5'b01111, 1'b0}) begin
            failures++;
            $display("FAIL full_block got rdy=%b ghr=%b we=%b exp 0/01111/0", d_pre_ready, bus.ghr_spec, bus.pht_we);
        end
    endtask

    task automatic test_resolve_correct();
        tick(0, 0, 0, 1, 0, 1);
        checks++;
        if ({bus.pht_we, bus.pht_init, bus.pht_waddr, bus.pht_inc, bus.flush, bus.ghr_spec, bus.if_ready}
            !== {1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 5'b01111, 1'b1}) begin
            failures++;
            $display("FAIL resolve_correct got we=%b init=%b addr=%0d inc=%b flush=%b ghr=%b rdy=%b",
                     bus.pht_we, bus.pht_init, bus.pht_waddr, bus.pht_inc, bus.flush, bus.ghr_spec, bus.if_ready);
        end
    endtask

    task automatic test_mispredict();
        tick(0, 0, 0, 1, 1, 0);
        checks++;
        if ({bus.flush, bus.ghr_spec, bus.pht_we, bus.pht_waddr, bus.pht_inc, bus.if_ready}
            !== {1'b1, 5'b00010, 1'b1, 5'd3, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL mispredict got flush=%b ghr=%b we=%b addr=%0d inc=%b rdy=%b",
                     bus.flush, bus.ghr_spec, bus.pht_we, bus.pht_waddr, bus.pht_inc, bus.if_ready);
        end
        tick(0, 0, 0, 0, 0, 0);
        checks++;
        if ({d_pre_ready, bus.flush, bus.if_ready, bus.if_tag, bus.pht_we} !== {1'b0, 1'b0, 1'b1, 2'd0, 1'b0}) begin
            failures++;
            $display("FAIL recover got pre_rdy=%b flush=%b rdy=%b tag=%0d we=%b",
                     d_pre_ready, bus.flush, bus.if_ready, bus.if_tag, bus.pht_we);
        end
    endtask

    task automatic test_alloc_during_mispredict();
        tick(1, 5, 0, 0, 0, 0);
        tick(1, 6, 1, 0, 0, 0);
        checks++;
        if (bus.ghr_spec !== 5'b01001) begin
            failures++;
            $display("FAIL pre_squash_ghr got=%b exp=01001", bus.ghr_spec);
        end
        tick(1, 8, 1, 1, 0, 1);
        checks++;
        if ({bus.flush, bus.ghr_spec, bus.pht_we, bus.pht_waddr, bus.pht_inc} !== {1'b1, 5'b00101, 1'b1, 5'd5, 1'b1}) begin
            failures++;
            $display("FAIL squash_alloc got flush=%b ghr=%b we=%b addr=%0d inc=%b",
                     bus.flush, bus.ghr_spec, bus.pht_we, bus.pht_waddr, bus.pht_inc);
        end
        tick(0, 0, 0, 0, 0, 0);
        checks++;
        if ({bus.if_tag, bus.ghr_spec, bus.if_ready} !== {2'd0, 5'b00101, 1'b1}) begin
            failures++;
            $display("FAIL squash_after got tag=%0d ghr=%b rdy=%b exp 0/00101/1", bus.if_tag, bus.ghr_spec, bus.if_ready);
        end
    endtask

    task automatic test_errors();
        checks++;
        if (bus.err !== 1'b0) begin
            failures++;
            $display("FAIL err_clean got=%b exp=0", bus.err);
        end
        tick(0, 0, 0, 1, 2, 1);
        checks++;
        if ({bus.pht_we, bus.err, bus.flush} !== 3'b010) begin
            failures++;
            $display("FAIL err_empty got we=%b err=%b flush=%b exp 0/1/0", bus.pht_we, bus.err, bus.flush);
        end
        tick(1, 4, 1, 0, 0, 0);
        tick(0, 0, 0, 1, 3, 0);
        checks++;
        if ({bus.pht_we, bus.err, bus.flush, bus.ghr_spec} !== {1'b0, 1'b1, 1'b0, 5'b01011}) begin
            failures++;
            $display("FAIL err_tag got we=%b err=%b flush=%b ghr=%b", bus.pht_we, bus.err, bus.flush, bus.ghr_spec);
        end
        tick(0, 0, 0, 1, 0, 1);
        checks++;
        if ({bus.pht_we, bus.pht_waddr, bus.err} !== {1'b1, 5'd4, 1'b1}) begin
            failures++;
            $display("FAIL err_sticky got we=%b addr=%0d err=%b exp 1/4/1", bus.pht_we, bus.pht_waddr, bus.err);
        end
    endtask

    task automatic test_random();
        logic [15:0] got, exp;
        int tag;
        for (int n = 0; n < 600; n++) begin
            if (m_q.size() > 0 && $urandom_range(0, 9) < 7) tag = m_q[0].tag;
            else tag = int'($urandom_range(0, DEPTH - 1));
            tick($urandom_range(0, 1), $urandom_range(0, NENT - 1), $urandom_range(0, 1),
                 ($urandom_range(0, 9) < 3), tag, $urandom_range(0, 1));
            got = {bus.pht_we, bus.pht_init, bus.pht_inc, bus.flush, bus.err, bus.pht_waddr, bus.ghr_spec};
            exp = {e_we, e_init, e_inc, e_flush, e_err, 5'(e_waddr), 5'(m_ghr)};
            checks++;
            if (got !== exp || d_pre_ready !== m_pre_ready || d_pre_tag !== 2'(m_pre_tag)) begin
                failures++;
                $display("FAIL random cycle %0d got=%h rdy=%b tag=%0d exp=%h rdy=%b tag=%0d",
                         n, got, d_pre_ready, d_pre_tag, exp, m_pre_ready, m_pre_tag);
            end
        end
    endtask

    task automatic test_reset_mid_init();
        drive_idle();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) tick(0, 0, 0, 0, 0, 0);
        checks++;
        if ({bus.pht_we, bus.pht_waddr} !== {1'b1, 5'd10}) begin
            failures++;
            $display("FAIL mid_init_addr got we=%b addr=%0d exp 1/10", bus.pht_we, bus.pht_waddr);
        end
        tick(0, 0, 0, 1, 0, 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({bus.pht_we, bus.pht_init, bus.pht_waddr, bus.err} !== {1'b1, 1'b1, 5'd0, 1'b0}) begin
            failures++;
            $display("FAIL mid_init_reset got we=%b init=%b addr=%0d err=%b", bus.pht_we, bus.pht_init, bus.pht_waddr, bus.err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick(0, 0, 0, 0, 0, 0);
            checks++;
            if (bus.pht_waddr !== 5'(i) || bus.pht_waddr !== 5'(e_waddr)) begin
                failures++;
                $display("FAIL restart_sweep got addr=%0d exp=%0d", bus.pht_waddr, i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_resolve_correct();
        test_mispredict();
        test_alloc_during_mispredict();
        test_errors();
        test_reset();
        test_random();
        test_reset_mid_init();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
